// File: rtl/aux_sample_ctrl.sv
// ============================================================================
//  Module      : aux_sample_ctrl
//  Description : Periodic sampler for auxiliary inputs. It raises a
//                request/acknowledge event when unmasked bits change.
//                Define AUX_DEBOUNCE_EN to add per-bit debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aux_sample_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16,
  parameter int DB_CNT = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] aux_in,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             evt_ack,
  output logic [WIDTH-1:0] aux_i,
  output logic [WIDTH-1:0] aux_chg,
  output logic             evt_req,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_NOTIFY = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_aux_i, w_aux_i_nxt;
  logic [WIDTH-1:0] r_aux_chg, w_aux_chg_nxt;
  logic             r_evt_req, w_evt_req_nxt;
  logic             r_busy;
  logic             w_sample;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_diff;

  // An aborting cfg_en suppresses the sample, so debounce history is not advanced.
  assign w_sample = (r_state == S_SAMPLE) && cfg_en;
  assign w_toggle = aux_in ^ r_aux_i;
  assign w_diff   = w_accept & cfg_mask;

  // Holds only for an illegal DB_CNT; the block is intentionally empty.
  if (DB_CNT < 1) begin : g_db_cnt_invalid
  end

`ifdef AUX_DEBOUNCE_EN
  localparam int DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DB_CNT - 1);

  logic [WIDTH-1:0][DB_W-1:0] r_db;

  // A bit is accepted on the sample that would complete DB_CNT consecutive differences.
  always_comb begin
    w_accept = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_accept[b] = w_toggle[b] && (r_db[b] == C_DB_LAST);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_db <= '0;
    end else if (w_sample) begin
      for (int b = 0; b < WIDTH; b++) begin
        r_db[b] <= (w_toggle[b] && !w_accept[b]) ? r_db[b] + 1'b1 : '0;
      end
    end
  end
`else
  assign w_accept = w_toggle;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_aux_i   <= '0;
      r_aux_chg <= '0;
      r_evt_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_aux_i   <= w_aux_i_nxt;
      r_aux_chg <= w_aux_chg_nxt;
      r_evt_req <= w_evt_req_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_aux_i_nxt   = r_aux_i;
    w_aux_chg_nxt = r_aux_chg;
    w_evt_req_nxt = r_evt_req;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (cfg_en) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = cfg_period;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SAMPLE: begin
        w_aux_i_nxt   = (r_aux_i & ~w_accept) | (aux_in & w_accept);
        w_aux_chg_nxt = r_aux_chg | w_diff;
        if (|w_diff) begin
          w_state_nxt   = S_NOTIFY;
          w_evt_req_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = cfg_period;
        end
      end
      S_NOTIFY: begin
        w_evt_req_nxt = 1'b1;
        if (evt_ack) begin
          w_state_nxt   = S_WAIT;
          w_cnt_nxt     = cfg_period;
          w_evt_req_nxt = 1'b0;
          w_aux_chg_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Disable wins over everything, including a simultaneous acknowledge.
    if (!cfg_en) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_aux_i_nxt   = r_aux_i;
      w_aux_chg_nxt = '0;
      w_evt_req_nxt = 1'b0;
    end
  end

  assign aux_i   = r_aux_i;
  assign aux_chg = r_aux_chg;
  assign evt_req = r_evt_req;
  assign busy    = r_busy;

endmodule

`default_nettype wire
